chipregs_mm_arbiter: RTL

- Shares the single chipregs MM register slave (10-bit address, 64-bit data, strobe-based read/write with delayed read-valid) between pNUM_REQ independent masters, e.g. the PCIe BAR path and the on-board debug/UART path.
- Round-robin grant, one outstanding transaction at a time, and a read-response watchdog so a slave that never returns rd_data_v cannot hang any master.
- Sits between the masters and chipregs_wrap, in the 100 MHz domain.

---
 rtl/chipregs_mm_arb_pkg.sv | 18 +
 rtl/chipregs_mm_arbiter_rr.sv | 34 +++
 rtl/chipregs_mm_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/chipregs_mm_arb_pkg.sv
// Shared types and constants for the chipregs MM arbiter.
// Bus widths mirror the chipregs register slave.
package chipregs_mm_arb_pkg;

    localparam int MM_ADDR_W = 10;
    localparam int MM_DATA_W = 64;

    localparam logic [MM_DATA_W-1:0] TIMEOUT_DATA_DEF =
        64'hDEAD_DEAD_DEAD_DEAD;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        ACK
    } arb_state_t;

endpackage

// File: rtl/chipregs_mm_arbiter_rr.sv
// Combinational round-robin pick: first requester at or
// after lastGrant+1, returned as one-hot and as an index.
module mm_rr_arbiter #(
    parameter int pNUM_REQ = 2,
    parameter int IDX_W    = $clog2(pNUM_REQ)
) (
    input  logic [pNUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]    lastGrant,
    output logic [pNUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]    idx,
    output logic                anyReq
);

    logic found;

    assign anyReq = |req;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= pNUM_REQ; i++) begin
            for (int j = 0; j < pNUM_REQ; j++) begin
                if (!found && req[j] &&
                    j == (int'(lastGrant) + i) % pNUM_REQ) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/chipregs_mm_arbiter.sv
// Round-robin sharing of the chipregs MM slave between masters,
// one transaction in flight, with a read-response watchdog.
module chipregs_mm_arbiter
    import chipregs_mm_arb_pkg::*;
#(
    parameter int                    pNUM_REQ      = 2,
    parameter int                    pRD_TIMEOUT   = 64,
    parameter logic [MM_DATA_W-1:0]  pTIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
    input  logic                            iCLK_100M,
    input  logic                            iRST_100M_n,
    input  logic [pNUM_REQ-1:0]             iREQ_WR_EN,
    input  logic [pNUM_REQ-1:0]             iREQ_RD_EN,
    input  logic [pNUM_REQ*MM_ADDR_W-1:0]   iREQ_ADDRESS,
    input  logic [pNUM_REQ*MM_DATA_W-1:0]   iREQ_WR_DATA,
    output logic [pNUM_REQ-1:0]             oREQ_ACK,
    output logic [MM_DATA_W-1:0]            oREQ_RD_DATA,
    output logic                            oMM_WR_EN,
    output logic                            oMM_RD_EN,
    output logic [MM_ADDR_W-1:0]            oMM_ADDRESS,
    output logic [MM_DATA_W-1:0]            oMM_WR_DATA,
    input  logic [MM_DATA_W-1:0]            iMM_RD_DATA,
    input  logic                            iMM_RD_DATA_V,
    input  logic                            iCLR_STATS,
    output logic [15:0]                     oTIMEOUT_CNT,
    output logic [7:0]                      oSTRAY_RDV_CNT,
    output logic [MM_ADDR_W-1:0]            oLAST_TIMEOUT_ADDR
);

    localparam int IDX_W = $clog2(pNUM_REQ);
    localparam int TMR_W = $clog2(pRD_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(pRD_TIMEOUT - 1);

    arb_state_t            state;
    logic [IDX_W-1:0]      lastGrant;
    logic [IDX_W-1:0]      grantIdx;
    logic [pNUM_REQ-1:0]   grantOh;
    logic                  isWr;
    logic [TMR_W-1:0]      timer;

    logic [pNUM_REQ-1:0]   req;
    logic [pNUM_REQ-1:0]   pickOh;
    logic [IDX_W-1:0]      pickIdx;
    logic                  anyReq;
    logic                  pickWr;
    logic [MM_ADDR_W-1:0]  pickAddr;
    logic [MM_DATA_W-1:0]  pickData;
    logic                  timeoutEvt;
    logic                  strayEvt;

    assign req = iREQ_WR_EN | iREQ_RD_EN;

    mm_rr_arbiter #(
        .pNUM_REQ (pNUM_REQ),
        .IDX_W    (IDX_W)
    ) uRr (
        .req       (req),
        .lastGrant (lastGrant),
        .grant     (pickOh),
        .idx       (pickIdx),
        .anyReq    (anyReq)
    );

    // Write takes precedence when a master raises both enables.
    assign pickWr = |(pickOh & iREQ_WR_EN);

    always_comb begin
        pickAddr = '0;
        pickData = '0;
        for (int i = 0; i < pNUM_REQ; i++) begin
            if (pickOh[i]) begin
                pickAddr = iREQ_ADDRESS[i*MM_ADDR_W +: MM_ADDR_W];
                pickData = iREQ_WR_DATA[i*MM_DATA_W +: MM_DATA_W];
            end
        end
    end

    assign timeoutEvt = (state == WAIT_RD) && !iMM_RD_DATA_V &&
                        (timer == TMR_LAST);
    assign strayEvt   = iMM_RD_DATA_V && (state != WAIT_RD);

    always_ff @(posedge iCLK_100M or negedge iRST_100M_n) begin
        if (!iRST_100M_n) begin
            state        <= IDLE;
            lastGrant    <= IDX_W'(pNUM_REQ - 1);
            grantIdx     <= '0;
            grantOh      <= '0;
            isWr         <= 1'b0;
            timer        <= '0;
            oREQ_ACK     <= '0;
            oREQ_RD_DATA <= '0;
            oMM_WR_EN    <= 1'b0;
            oMM_RD_EN    <= 1'b0;
            oMM_ADDRESS  <= '0;
            oMM_WR_DATA  <= '0;
        end else begin
            oMM_WR_EN <= 1'b0;
            oMM_RD_EN <= 1'b0;
            oREQ_ACK  <= '0;
            unique case (state)
                IDLE: begin
                    if (anyReq) begin
                        grantIdx    <= pickIdx;
                        grantOh     <= pickOh;
                        isWr        <= pickWr;
                        oMM_ADDRESS <= pickAddr;
                        oMM_WR_DATA <= pickData;
                        oMM_WR_EN   <= pickWr;
                        oMM_RD_EN   <= !pickWr;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (isWr) begin
                        oREQ_RD_DATA <= '0;
                        oREQ_ACK     <= grantOh;
                        state        <= ACK;
                    end else begin
                        timer <= '0;
                        state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (iMM_RD_DATA_V) begin
                        oREQ_RD_DATA <= iMM_RD_DATA;
                        oREQ_ACK     <= grantOh;
                        state        <= ACK;
                    end else if (timeoutEvt) begin
                        oREQ_RD_DATA <= pTIMEOUT_DATA;
                        oREQ_ACK     <= grantOh;
                        state        <= ACK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ACK: begin
                    lastGrant    <= grantIdx;
                    oREQ_RD_DATA <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A clear in the same cycle as an event wins.
    always_ff @(posedge iCLK_100M or negedge iRST_100M_n) begin
        if (!iRST_100M_n) begin
            oTIMEOUT_CNT       <= '0;
            oSTRAY_RDV_CNT     <= '0;
            oLAST_TIMEOUT_ADDR <= '0;
        end else if (iCLR_STATS) begin
            oTIMEOUT_CNT       <= '0;
            oSTRAY_RDV_CNT     <= '0;
            oLAST_TIMEOUT_ADDR <= '0;
        end else begin
            if (timeoutEvt) begin
                oLAST_TIMEOUT_ADDR <= oMM_ADDRESS;
                if (oTIMEOUT_CNT != 16'hFFFF)
                    oTIMEOUT_CNT <= oTIMEOUT_CNT + 16'd1;
            end
            if (strayEvt && oSTRAY_RDV_CNT != 8'hFF)
                oSTRAY_RDV_CNT <= oSTRAY_RDV_CNT + 8'd1;
        end
    end

endmodule
